switch_reader: RTL and testbench

- Avalon-MM slave peripheral that the Nios II processor polls to read the board slide switches.
- It is the input-direction counterpart of the hex display output peripherals.
- Synchronises and debounces WIDTH raw switch lines, latches per-bit change events, and raises a maskable interrupt.
- Instantiated inside the Qsys system; its conduit export drives from the top-level SW pins.

---
 rtl/switch_reader.sv | 225 ++++++++++++++++++++++
 tb/tb_switch_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_reader.sv
`default_nettype none
// ============================================================================
//  Module      : switch_reader
//  Description : Avalon-MM slave that synchronises and debounces the board
//                slide switches, latches per-bit change events (W1C) and
//                raises a maskable level interrupt.
//                Optional macro SWITCH_READER_BCD_EN adds a sequential
//                binary-to-BCD converter readable at word address 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_reader #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int             CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_deb;
    logic             r_primed;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_rdata;
    logic             r_irq;

    logic             w_stable;
    logic             w_expired;
    logic             w_commit;
    logic [WIDTH-1:0] w_new_edges;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr_mask;
    logic [31:0]      w_rmux;
    logic [31:0]      w_bcd_word;
    logic             w_unused_wdata;

    assign w_stable  = (r_sync == r_cand);
    assign w_expired = (r_cnt == C_CNT_MAX);
    // The counter parks at its maximum, so only fire once per new value
    // (the very first value after reset always commits to prime the block).
    assign w_commit    = w_stable && w_expired && (!r_primed || (r_cand != r_deb));
    assign w_new_edges = r_primed ? (r_cand ^ r_deb) : '0;
    assign w_clr       = (write && (address == 2'd1)) ? writedata[WIDTH-1:0] : '0;
    assign w_wr_mask   = write && (address == 2'd2);
    // Upper write-data bits have no destination when WIDTH < 32.
    assign w_unused_wdata = ^writedata;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= switches;
            r_sync <= r_meta;
        end
    end

    // Shared stability counter: restart on any change, saturate when expired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else if (!w_stable) begin
            r_cand <= r_sync;
            r_cnt  <= '0;
        end else if (!w_expired) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Commit the debounced value; the first commit only primes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb    <= '0;
            r_primed <= 1'b0;
        end else if (w_commit) begin
            r_deb    <= r_cand;
            r_primed <= 1'b1;
        end
    end

    // Edge latch: W1C, with a same-cycle new edge taking priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | (w_commit ? w_new_edges : '0);
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_wr_mask) begin
            r_mask <= writedata[WIDTH-1:0];
        end
    end

    // Registered level interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge & r_mask);
        end
    end

`ifdef SWITCH_READER_BCD_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } bcd_state_t;

    localparam int BITS_W = $clog2(WIDTH + 1);

    bcd_state_t        r_state;
    bcd_state_t        w_state_nxt;
    logic [WIDTH-1:0]  r_bin;
    logic [19:0]       r_work;
    logic [BITS_W-1:0] r_bits;
    logic [19:0]       r_bcd;
    logic [19:0]       w_adj;
    logic [19:0]       w_work_nxt;

    // Converter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a commit always (re)starts the conversion.
    always_comb begin
        w_state_nxt = r_state;
        if (w_commit) begin
            w_state_nxt = S_SHIFT;
        end else begin
            case (r_state)
                S_SHIFT: w_state_nxt = (r_bits == BITS_W'(1)) ? S_DONE : S_SHIFT;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // One shift-add-3 step: correct each digit >= 5, then shift in the next bit.
    always_comb begin
        w_adj = r_work;
        for (int d = 0; d < 5; d++) begin
            if (w_adj[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = w_adj[4*d +: 4] + 4'd3;
            end
        end
        w_work_nxt = {w_adj[18:0], r_bin[WIDTH-1]};
    end

    // Converter datapath; the visible BCD image only changes at completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin  <= '0;
            r_work <= '0;
            r_bits <= '0;
            r_bcd  <= '0;
        end else if (w_commit) begin
            r_bin  <= r_cand;
            r_work <= '0;
            r_bits <= BITS_W'(WIDTH);
        end else if (r_state == S_SHIFT) begin
            r_work <= w_work_nxt;
            r_bin  <= r_bin << 1;
            r_bits <= r_bits - BITS_W'(1);
        end else if (r_state == S_DONE) begin
            r_bcd  <= r_work;
        end
    end

    assign w_bcd_word = 32'(r_bcd);
`else
    assign w_bcd_word = 32'd0;
`endif

    // Read-data source selection.
    always_comb begin
        w_rmux = 32'd0;
        case (address)
            2'd0: w_rmux = 32'(r_deb);
            2'd1: w_rmux = 32'(r_edge);
            2'd2: w_rmux = 32'(r_mask);
            2'd3: w_rmux = w_bcd_word;
            default: w_rmux = 32'd0;
        endcase
    end

    // Read data register, latency 1, holds when no read is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if (read) begin
            r_rdata <= w_rmux;
        end
    end

    assign readdata = r_rdata;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_switch_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_reader
//  Description : Self-checking bench for switch_reader (WIDTH=16,
//                DEBOUNCE_CYCLES=4): directed sequences, a vector table and
//                a randomized run against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_reader;

    localparam int W  = 16;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  switches;
    logic [1:0]    address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;

    int n_cmp = 0;
    int n_bad = 0;

    switch_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .switches  (switches),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [W-1:0] q_sync[$];     // recent synchronised samples
    logic [W-1:0] m_s1, m_s2, m_deb, m_edge, m_mask;
    bit           m_primed, m_irq;
    logic [31:0]  m_rd, m_bcd;
    logic [W-1:0] m_bcd_val;
    int           m_bcd_cnt;

    function automatic logic [31:0] to_bcd(input logic [W-1:0] v);
        int x = int'(v);
        logic [31:0] r = 32'd0;
        for (int d = 0; d < 5; d++) begin
            r = r | (32'(x % 10) << (4 * d));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        q_sync.delete();
        q_sync.push_back('0);
        q_sync.push_back('0);
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_edge = '0; m_mask = '0;
        m_primed = 0; m_irq = 0; m_rd = 32'd0; m_bcd = 32'd0;
        m_bcd_val = '0; m_bcd_cnt = 0;
    endtask

    // One clock edge: a value commits once it has been seen unchanged for
    // DC+1 consecutive synchronised samples and differs from the last commit.
    task automatic model_step(input logic [W-1:0] sw, input bit rd, input bit wr,
                              input logic [1:0] a, input logic [31:0] wd);
        bit           commit;
        bit           irq_n;
        logic [W-1:0] v, clr;
        if (rd) begin
            case (a)
                2'd0: m_rd = 32'(m_deb);
                2'd1: m_rd = 32'(m_edge);
                2'd2: m_rd = 32'(m_mask);
                default: begin
`ifdef SWITCH_READER_BCD_EN
                    m_rd = m_bcd;
`else
                    m_rd = 32'd0;
`endif
                end
            endcase
        end
        irq_n  = |(m_edge & m_mask);
        commit = 0;
        v      = q_sync[0];
        if (q_sync.size() == DC + 1) begin
            commit = 1;
            for (int k = 1; k < q_sync.size(); k++)
                if (q_sync[k] != v) commit = 0;
            if (m_primed && v == m_deb) commit = 0;
        end
        clr = (wr && a == 2'd1) ? wd[W-1:0] : '0;
        m_edge = (m_edge & ~clr) | ((commit && m_primed) ? (v ^ m_deb) : '0);
        if (wr && a == 2'd2) m_mask = wd[W-1:0];
        if (commit) begin
            m_bcd_cnt = W + 1;
            m_bcd_val = v;
        end else if (m_bcd_cnt > 0) begin
            m_bcd_cnt--;
            if (m_bcd_cnt == 0) m_bcd = to_bcd(m_bcd_val);
        end
        if (commit) begin
            m_deb = v;
            m_primed = 1;
        end
        m_irq = irq_n;
        m_s2 = m_s1;
        m_s1 = sw;
        q_sync.push_back(m_s2);
        if (q_sync.size() > DC + 1) void'(q_sync.pop_front());
    endtask

    typedef struct {
        logic [W-1:0] sw;
        logic [W-1:0] exp_data;
        logic [W-1:0] exp_edge;
    } vec_t;
    vec_t tbl[7];

    logic [31:0] d;
    logic [31:0] exp_bcd;
    bit          r_rd, r_wr;
    logic [1:0]  r_a;
    logic [31:0] r_wd;
    int          op;

    initial begin
        tbl[0] = '{16'h00A4, 16'h00A4, 16'hFF5B};
        tbl[1] = '{16'h00A4, 16'h00A4, 16'h0000};
        tbl[2] = '{16'hFF00, 16'hFF00, 16'hFFA4};
        tbl[3] = '{16'h0F0F, 16'h0F0F, 16'hF00F};
        tbl[4] = '{16'h0000, 16'h0000, 16'h0F0F};
        tbl[5] = '{16'h8001, 16'h8001, 16'h8001};
        tbl[6] = '{16'h7FFE, 16'h7FFE, 16'hFFFF};

        reset = 1'b1; switches = 16'h00A5; address = 2'd0;
        read = 1'b0; write = 1'b0; writedata = 32'd0;
        tick(2);
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        reset = 1'b0;

        // Priming commit loads the value without edges.
        tick(10);
        bus_read(2'd0, d); chk("prime_data", d, 32'h000000A5);
        bus_read(2'd1, d); chk("prime_edge", d, 32'd0);
        chk("prime_irq", 32'(irq), 32'd0);

        bus_write(2'd2, 32'hFFFF_0001);
        bus_read(2'd2, d); chk("mask_rw", d, 32'h00000001);
        bus_write(2'd0, 32'h0000_1234);
        bus_read(2'd0, d); chk("data_ro", d, 32'h000000A5);

        // Commit latency and irq timing.
        switches = 16'h00A4;
        tick(6);
        bus_read(2'd0, d); chk("latency_old", d, 32'h000000A5);
        chk("irq_before", 32'(irq), 32'd0);
        tick(1);
        chk("irq_after", 32'(irq), 32'd1);
        bus_read(2'd0, d); chk("latency_new", d, 32'h000000A4);
        bus_read(2'd1, d); chk("edge_set", d, 32'h00000001);
        bus_write(2'd1, 32'h0000_0001);
        chk("irq_lag", 32'(irq), 32'd1);
        tick(1);
        chk("irq_drop", 32'(irq), 32'd0);
        bus_read(2'd1, d); chk("edge_w1c", d, 32'd0);

        // Short glitch must not commit.
        switches = 16'h00AC;
        tick(3);
        switches = 16'h00A4;
        tick(10);
        bus_read(2'd0, d); chk("glitch_data", d, 32'h000000A4);
        bus_read(2'd1, d); chk("glitch_edge", d, 32'd0);

        // W1C in the same cycle as a new edge on that bit: set wins.
        switches = 16'h00A5;
        tick(10);
        bus_read(2'd1, d); chk("pre_race_edge", d, 32'h00000001);
        switches = 16'h00A4;
        tick(6);
        bus_write(2'd1, 32'h0000_0001);
        bus_read(2'd1, d); chk("race_edge", d, 32'h00000001);
        bus_read(2'd0, d); chk("race_data", d, 32'h000000A4);

        // Reset in the middle of a debounce.
        switches = 16'hFFFF;
        tick(3);
        pulse_reset();
        chk("midrst_readdata", readdata, 32'd0);
        chk("midrst_irq", 32'(irq), 32'd0);
        bus_read(2'd0, d); chk("midrst_data", d, 32'd0);
        bus_read(2'd1, d); chk("midrst_edge", d, 32'd0);
        bus_read(2'd2, d); chk("midrst_mask", d, 32'd0);
        tick(10);
        bus_read(2'd0, d); chk("reprime_data", d, 32'h0000FFFF);
        bus_read(2'd1, d); chk("reprime_edge", d, 32'd0);
        chk("reprime_irq", 32'(irq), 32'd0);

        // Address 3: BCD image (or zero without the converter).
        switches = 16'h0000;
        tick(30);
        switches = 16'hFFFF;
`ifdef SWITCH_READER_BCD_EN
        exp_bcd = 32'h00065535;
`else
        exp_bcd = 32'd0;
`endif
        tick(6 + W + 1);
        bus_read(2'd3, d); chk("bcd_busy", d, 32'd0);
        bus_read(2'd3, d); chk("bcd_done", d, exp_bcd);

        // Vector table.
        bus_write(2'd2, 32'h0000_FFFF);
        for (int i = 0; i < 7; i++) begin
            bus_write(2'd1, 32'h0000_FFFF);
            switches = tbl[i].sw;
            tick(12);
            bus_read(2'd0, d); chk($sformatf("tbl%0d_data", i), d, 32'(tbl[i].exp_data));
            bus_read(2'd1, d); chk($sformatf("tbl%0d_edge", i), d, 32'(tbl[i].exp_edge));
            chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].exp_edge != 0));
        end

        // Randomized run against the model.
        switches = 16'($urandom);
        pulse_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) switches = switches ^ 16'($urandom);
            op = int'($urandom_range(9));
            r_rd = 0; r_wr = 0;
            r_a  = 2'($urandom_range(3));
            r_wd = $urandom;
            if (op == 0)      begin r_wr = 1; r_a = 2'd1; end
            else if (op == 1) begin r_wr = 1; r_a = 2'd2; end
            else if (op == 2) r_wr = 1;
            else              r_rd = 1;
            address = r_a; writedata = r_wd; read = r_rd; write = r_wr;
            @(negedge clk);
            model_step(switches, r_rd, r_wr, r_a, r_wd);
            chk($sformatf("rand%0d_readdata", i), readdata, m_rd);
            chk($sformatf("rand%0d_irq", i), 32'(irq), 32'(m_irq));
        end
        read = 1'b0; write = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
